// File: rtl/parking_controller.sv
// Four-slot parking lot controller: debounced entry/exit requests drive a
// single gate FSM that allocates the lowest free slot and times the barrier.

module parking_debounce #(
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic event_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [1:0]    sync_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ev_q;
    logic          ev_d;

    // Synchronizer shift, saturating stable-high counter and one-shot event.
    always_comb begin
        sync_d = {sync_q[0], req};
        cnt_d  = cnt_q;
        ev_d   = 1'b0;
        if (sync_q[1]) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
            ev_d = (cnt_q == CNT_PRE);
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
            ev_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            ev_q   <= ev_d;
        end
    end

    assign event_pulse = ev_q;
endmodule

module parking_controller #(
    parameter int GATE_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic       clk_500Hz,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_slot,
    output logic [2:0] empty_slot,
    output logic [2:0] capacity,
    output logic       gate_open,
    output logic [2:0] assigned_slot,
    output logic       denied,
    output logic       err
);
    localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2
    } state_t;

    function automatic logic [2:0] free_count(input logic [3:0] occ);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~occ[i]};
        end
        return n;
    endfunction

    function automatic logic [2:0] lowest_free(input logic [3:0] occ);
        logic [2:0] idx;
        casez (occ)
            4'b???0: idx = 3'd0;
            4'b??01: idx = 3'd1;
            4'b?011: idx = 3'd2;
            4'b0111: idx = 3'd3;
            default: idx = 3'b111;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] slot_mask(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    logic          entry_ev_s;
    logic          exit_ev_s;
    logic [2:0]    empty_s;
    state_t        state_q;
    state_t        state_d;
    logic [3:0]    occ_q;
    logic [3:0]    occ_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          gate_q;
    logic          gate_d;
    logic [2:0]    assigned_q;
    logic [2:0]    assigned_d;
    logic          denied_q;
    logic          denied_d;
    logic          err_q;
    logic          err_d;

    parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
        .clk         (clk_500Hz),
        .reset       (reset),
        .req         (entry_req),
        .event_pulse (entry_ev_s)
    );

    parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
        .clk         (clk_500Hz),
        .reset       (reset),
        .req         (exit_req),
        .event_pulse (exit_ev_s)
    );

    assign empty_s = lowest_free(occ_q);

    // Gate FSM: exit wins over a simultaneous entry; events while open are dropped.
    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        timer_d    = timer_q;
        gate_d     = gate_q;
        assigned_d = assigned_q;
        denied_d   = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (exit_ev_s) begin
                    if (occ_q[exit_slot]) begin
                        occ_d   = occ_q & ~slot_mask(exit_slot);
                        gate_d  = 1'b1;
                        timer_d = TIMER_LOAD;
                        state_d = EXIT_OPEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (entry_ev_s) begin
                    if (empty_s != 3'b111) begin
                        occ_d      = occ_q | slot_mask(empty_s[1:0]);
                        assigned_d = empty_s;
                        gate_d     = 1'b1;
                        timer_d    = TIMER_LOAD;
                        state_d    = ENTRY_OPEN;
                    end else begin
                        denied_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
                if (timer_q == '0) begin
                    gate_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                gate_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk_500Hz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            occ_q      <= 4'b0000;
            timer_q    <= '0;
            gate_q     <= 1'b0;
            assigned_q <= 3'b111;
            denied_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            timer_q    <= timer_d;
            gate_q     <= gate_d;
            assigned_q <= assigned_d;
            denied_q   <= denied_d;
            err_q      <= err_d;
        end
    end

    assign empty_slot    = empty_s;
    assign capacity      = free_count(occ_q);
    assign gate_open     = gate_q;
    assign assigned_slot = assigned_q;
    assign denied        = denied_q;
    assign err           = err_q;
endmodule

// File: tb/tb_parking_controller.sv
// Randomized scoreboard bench for parking_controller against a slot-list model.

module tb_parking_controller;
    localparam int GATE = 4;
    localparam int DEB  = 3;
    localparam int K_GRANT = 0;
    localparam int K_EXIT  = 1;
    localparam int K_DENY  = 2;
    localparam int K_ERR   = 3;

    typedef struct {
        int kind;
        int slot;
        int cap;
        int empty;
        int due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [1:0] exit_slot = 2'd0;
    logic [2:0] empty_slot;
    logic [2:0] capacity;
    logic [2:0] assigned_slot;
    logic       gate_open;
    logic       denied;
    logic       err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];
    bit   occ[4];
    int   last_slot = 7;
    int   gate_len = 0;
    int   den_len = 0;
    int   err_len = 0;

    parking_controller #(.GATE_CYCLES(GATE), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk_500Hz     (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_slot     (exit_slot),
        .empty_slot    (empty_slot),
        .capacity      (capacity),
        .gate_open     (gate_open),
        .assigned_slot (assigned_slot),
        .denied        (denied),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int model_cap();
        int c = 0;
        for (int i = 0; i < 4; i++) if (!occ[i]) c++;
        return c;
    endfunction

    function automatic int model_empty();
        for (int i = 0; i < 4; i++) if (!occ[i]) return i;
        return 7;
    endfunction

    task automatic model_apply(input bit en, input bit ex, input int xs, input int start);
        exp_t e;
        int s;
        if (ex) begin
            if (occ[xs]) begin
                occ[xs] = 1'b0;
                e.kind = K_EXIT;
            end else begin
                e.kind = K_ERR;
            end
        end else begin
            s = model_empty();
            if (s != 7) begin
                occ[s] = 1'b1;
                last_slot = s;
                e.kind = K_GRANT;
            end else begin
                e.kind = K_DENY;
            end
        end
        e.slot  = last_slot;
        e.cap   = model_cap();
        e.empty = model_empty();
        e.due   = start + 3 + DEB;
        q.push_back(e);
    endtask

    // cls: 0 gate opened, 1 denied pulse, 2 err pulse
    task automatic take(input int cls);
        exp_t e;
        int   ecls;
        if (q.size() == 0) begin
            check("unexpected_event", cls, -1);
            return;
        end
        e = q.pop_front();
        ecls = (e.kind == K_DENY) ? 1 : ((e.kind == K_ERR) ? 2 : 0);
        check("event_kind", cls, ecls);
        check("latency", cyc, e.due);
        check("assigned_slot", int'(assigned_slot), e.slot);
        check("capacity", int'(capacity), e.cap);
        check("empty_slot", int'(empty_slot), e.empty);
        if (cls != 0) check("gate_stays_closed", int'(gate_open), 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            gate_len = 0;
            den_len  = 0;
            err_len  = 0;
        end else begin
            if (gate_open) begin
                if (gate_len == 0) take(0);
                gate_len++;
            end else if (gate_len != 0) begin
                check("gate_len", gate_len, GATE);
                gate_len = 0;
            end
            if (denied) begin
                if (den_len == 0) take(1);
                den_len++;
            end else if (den_len != 0) begin
                check("denied_width", den_len, 1);
                den_len = 0;
            end
            if (err) begin
                if (err_len == 0) take(2);
                err_len++;
            end else if (err_len != 0) begin
                check("err_width", err_len, 1);
                err_len = 0;
            end
        end
    end

    task automatic do_op(input bit en, input bit ex, input int xs, input int hold);
        int n;
        @(posedge clk);
        #1;
        exit_slot = 2'(xs);
        entry_req = en;
        exit_req  = ex;
        if (hold >= DEB && (en || ex)) model_apply(en, ex, xs, cyc);
        repeat (hold) @(posedge clk);
        #1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        n = 0;
        while ((q.size() != 0 || gate_open) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("op_complete", int'(q.size() != 0 || gate_open), 0);
        q.delete();
        repeat (DEB + 3) @(posedge clk);
        #1;
        check("idle_capacity", int'(capacity), model_cap());
        check("idle_empty_slot", int'(empty_slot), model_empty());
    endtask

    initial begin
        int n;
        int r;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gate_open", int'(gate_open), 0);
        check("rst_capacity", int'(capacity), 4);
        check("rst_empty_slot", int'(empty_slot), 0);
        check("rst_assigned", int'(assigned_slot), 7);
        check("rst_denied", int'(denied), 0);
        check("rst_err", int'(err), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // long hold: single entry only, then fill, deny, refill freed slot
        do_op(1'b1, 1'b0, 0, 14);
        do_op(1'b1, 1'b0, 0, 5);
        do_op(1'b1, 1'b0, 0, 5);
        do_op(1'b1, 1'b0, 0, 5);
        do_op(1'b1, 1'b0, 0, 5);
        do_op(1'b0, 1'b1, 2, 5);
        do_op(1'b1, 1'b0, 0, 5);
        do_op(1'b0, 1'b1, 1, 5);
        do_op(1'b0, 1'b1, 2, 5);
        do_op(1'b0, 1'b1, 3, 5);
        do_op(1'b0, 1'b1, 3, 5);
        do_op(1'b1, 1'b0, 0, DEB);
        do_op(1'b1, 1'b1, 0, 6);
        do_op(1'b1, 1'b0, 0, DEB - 1);
        do_op(1'b0, 1'b1, 1, 1);

        for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      do_op(1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(DEB, 16));
            else if (r <= 6) do_op(1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(DEB, 16));
            else if (r == 7) do_op(1'b1, 1'b1, $urandom_range(0, 3), $urandom_range(DEB, 16));
            else             do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                   $urandom_range(0, 3), $urandom_range(1, DEB - 1));
        end

        for (int i = 0; i < 4; i++) if (occ[i]) do_op(1'b0, 1'b1, i, 5);

        // reset while the gate is open with two cycles left on the timer
        @(posedge clk);
        #1;
        entry_req = 1'b1;
        model_apply(1'b1, 1'b0, 0, cyc);
        n = 0;
        while (!gate_open && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_gate_open", int'(gate_open), 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_gate_open", int'(gate_open), 0);
        check("midrst_capacity", int'(capacity), 4);
        check("midrst_empty_slot", int'(empty_slot), 0);
        check("midrst_assigned", int'(assigned_slot), 7);
        entry_req = 1'b0;
        for (int i = 0; i < 4; i++) occ[i] = 1'b0;
        last_slot = 7;
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_gate_open", int'(gate_open), 0);
        check("post_rst_capacity", int'(capacity), 4);
        check("post_rst_assigned", int'(assigned_slot), 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/parking_controller.md
PARKING_CONTROLLER -- requirements
Module: parking_controller

Interface
REQ-001 Parameter GATE_CYCLES, default 1000, SHALL set the number of clk_500Hz cycles the gate stays open (2 s).
REQ-002 Parameter DEBOUNCE_CYCLES, default 10, SHALL set the consecutive stable-high cycles required to accept a request.
REQ-003 clk_500Hz  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 entry_req  in  1  asynchronous car-at-entry button/sensor.
REQ-006 exit_req  in  1  asynchronous car-at-exit button/sensor.
REQ-007 exit_slot  in  2  index of the slot being vacated; sampled on the exit event cycle.
REQ-008 empty_slot  out  3  lowest free slot index 0..3; 3'b111 when full.
REQ-009 capacity  out  3  number of free slots, 0..4.
REQ-010 gate_open  out  1  barrier drive, high while open.
REQ-011 assigned_slot  out  3  slot granted by the last entry; 3'b111 if none since reset.
REQ-012 denied  out  1  one-cycle pulse: entry refused, lot full.
REQ-013 err  out  1  one-cycle pulse: exit named an unoccupied slot.

Function
REQ-014 Each request input SHALL pass a 2-flop synchronizer, then a debouncer whose counter increments while the synced level is high (saturating at DEBOUNCE_CYCLES) and clears when it is low.
REQ-015 An event SHALL be a single-cycle pulse asserted on the cycle the counter reaches DEBOUNCE_CYCLES; a held input SHALL yield exactly one event.
REQ-016 Occupancy SHALL be a 4-bit register, bit i set = slot i occupied.
REQ-017 empty_slot and capacity SHALL be derived combinationally from the occupancy register (popcount, lowest-zero priority encoder).
REQ-018 FSM states SHALL be IDLE, ENTRY_OPEN and EXIT_OPEN.
REQ-019 In IDLE, an entry event with capacity>0: set the lowest free bit, load assigned_slot with its index, assert gate_open, load the timer to GATE_CYCLES-1, go to ENTRY_OPEN.
REQ-020 In IDLE, an entry event with capacity==0: pulse denied for one cycle, leave all other state unchanged, stay in IDLE.
REQ-021 In IDLE, an exit event with occupancy[exit_slot]==1: clear that bit, assert gate_open, load the timer to GATE_CYCLES-1, go to EXIT_OPEN.
REQ-022 In IDLE, an exit event with occupancy[exit_slot]==0: pulse err for one cycle, leave occupancy unchanged, stay in IDLE.
REQ-023 Entry and exit events in the same IDLE cycle: the exit SHALL be processed and the entry event discarded.
REQ-024 Events arriving in ENTRY_OPEN or EXIT_OPEN SHALL be discarded, with no denied or err pulse.
REQ-025 In the OPEN states the timer SHALL decrement each cycle; on the cycle it is 0, deassert gate_open and return to IDLE.
REQ-026 gate_open SHALL be high for exactly GATE_CYCLES cycles.
REQ-027 Latency SHALL be fixed: an input rising and held from edge 0 gives an event at edge 2+DEBOUNCE_CYCLES, and gate_open/occupancy update at edge 3+DEBOUNCE_CYCLES.
REQ-028 All outputs except empty_slot and capacity SHALL be registered.

Reset
REQ-029 While reset is low: occupancy=0, capacity=4, empty_slot=0, gate_open=0, assigned_slot=3'b111, denied=0, err=0, FSM=IDLE, timer=0, synchronizers and debounce counters=0.
REQ-030 Reset asserted mid-operation SHALL close the gate immediately and discard any pending event; after release, no event SHALL fire until an input is re-debounced from 0.

Verification (bench with GATE_CYCLES=4, DEBOUNCE_CYCLES=3)
REQ-031 Release reset, then hold entry_req high -> at edge 6 gate_open=1, assigned_slot=0, capacity=3, empty_slot=1; gate_open high for exactly 4 cycles; entry_req still held -> no second entry.
REQ-032 Perform four entries, then a fifth -> capacity=0, empty_slot=3'b111; the fifth gives a one-cycle denied pulse, gate_open stays 0, occupancy stays 4'b1111.
REQ-033 With occupancy 4'b1111, exit with exit_slot=2 -> capacity=1, empty_slot=2, gate_open for 4 cycles; the next entry gets assigned_slot=2.
REQ-034 With occupancy 4'b0001, exit with exit_slot=3 -> one-cycle err pulse; occupancy, capacity=3 and gate_open=0 unchanged.
REQ-035 Entry and exit events in the same cycle with occupancy 4'b0011 and exit_slot=0 -> occupancy=4'b0010, EXIT_OPEN, entry discarded, no denied pulse.
REQ-036 Assert reset during ENTRY_OPEN with the timer at 2 -> gate_open=0 and capacity=4 immediately; after release with inputs low, no event occurs.
